instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the team's R/I-type ALU instruction decoder: takes an ALU op code plus register and immediate fields and emits the 32-bit RV32I instruction word.
- Sits between the test/program generator and instruction memory. Attaches a sequential write address to every word, so programs can be loaded into imem.
- Valid/ready on both sides, with a 2-entry output buffer.

Parameters:
- ADDR_W, 32, width of the output write address.
- BASE_ADDR, 32'h0000_0000, first address after reset or restart.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  next pushed word gets BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept.
- in_alu_op  in  5  op code, same encoding the decoder produces.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2 (ignored for I-type).
- in_imm  in  32  immediate or shift amount (I-type only).
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for the word.
- err_illegal  out  1  one-cycle pulse: request dropped.
- illegal_cnt  out  8  saturating count of dropped requests.

Behaviour:
- Op codes:
  - ADD 0, ADDI 1, SUB 2, XOR 3, XORI 4, OR 5, ORI 6, AND 7, ANDI 8.
  - SLL 9, SLLI 10, SRL 11, SRLI 12, SRA 13, SRAI 14.
  - SLT 15, SLTI 16, SLTU 17, SLTIU 18.
  - Codes 19-31 are illegal.
- R-type word: funct7|rs2|rs1|funct3|rd|0110011.
  - funct7 = 0100000 for SUB and SRA, else 0000000.
  - funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- I-type word: imm[11:0]|rs1|funct3|rd|0010011, same funct3 table.
  - SLLI/SRLI/SRAI: bits[31:25] = funct7 (0100000 for SRAI, else 0), bits[24:20] = in_imm[4:0].
- Handshake: a request is accepted on in_valid & in_ready.
  - in_ready = (buffer count < 2), computed from registered state only.
  - A pop in the same cycle does not raise in_ready.
- Latency: an accepted legal request appears at out_valid on the next cycle when the buffer is empty.
- Buffer: 2-entry FIFO, in-order.
  - out_valid = count != 0; out_instr/out_addr show the head entry.
  - Pop occurs on out_valid & out_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Output data stays stable while out_valid & !out_ready.
- Address counter:
  - Each pushed word takes next_addr; next_addr then increments by 4, wrapping modulo 2^ADDR_W.
  - restart sets next_addr = BASE_ADDR.
  - restart in the same cycle as a push: that word gets BASE_ADDR and next_addr becomes BASE_ADDR+4.
  - Buffered words keep their assigned addresses.
- Illegal requests (bad op, or range failure, see Optional Feature):
  - Accepted (handshake completes) but not pushed; next_addr is unchanged.
  - err_illegal pulses high the following cycle.
  - illegal_cnt increments and saturates at 255.
- Reset values: count 0, out_valid 0, out_instr 0, out_addr 0, next_addr BASE_ADDR, err_illegal 0, illegal_cnt 0; in_ready is 1 after reset release.
- Reset asserted mid-operation clears the buffer immediately; buffered words are lost.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined:
  - I-type non-shift ops require in_imm to be sign-extended 12-bit (-2048..2047).
  - Shift-immediate ops require in_imm < 32.
  - A violation is treated as an illegal request.
- Undefined: no check; in_imm[11:0] or in_imm[4:0] is encoded silently and legality depends only on op code.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, out_ready=1 after reset -> next cycle out_instr=0x002081B3, out_addr=0x0.
- SUB rd=5 rs1=6 rs2=7 then ADDI rd=1 rs1=0 imm=-1 back-to-back -> words 0x407302B3 @0x0 and 0xFFF00093 @0x4.
- SRAI rd=4 rs1=4 imm=3 -> 0x40325213; then restart asserted with an ADD push -> that word addr=0x0.
- out_ready=0, push 3 ADDs -> in_ready=0 after 2 accepts; raise out_ready -> words pop in order at addrs 0x0, 0x4, then the third is accepted at 0x8.
- alu_op=25 -> accepted, no output word, err_illegal 1 cycle, illegal_cnt=1, next legal word keeps the expected address.
- ADDI imm=2048 -> with ENC_RANGE_CHECK_EN: dropped, err_illegal=1; without: out_instr=0x80000013 (rd=0, rs1=0).

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I R/I-type ALU instruction encoder with sequential imem write addresses and a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_alu_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        illegal_cnt
);
    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_i, is_sh, op_ok, range_ok, legal;
    logic [31:0] word;

    always_comb begin
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        is_i   = 1'b0;
        is_sh  = 1'b0;
        op_ok  = 1'b1;
        case (in_alu_op)
            5'd0:  ;
            5'd1:  is_i = 1'b1;
            5'd2:  funct7 = 7'b0100000;
            5'd3:  funct3 = 3'b100;
            5'd4:  begin funct3 = 3'b100; is_i = 1'b1; end
            5'd5:  funct3 = 3'b110;
            5'd6:  begin funct3 = 3'b110; is_i = 1'b1; end
            5'd7:  funct3 = 3'b111;
            5'd8:  begin funct3 = 3'b111; is_i = 1'b1; end
            5'd9:  funct3 = 3'b001;
            5'd10: begin funct3 = 3'b001; is_i = 1'b1; is_sh = 1'b1; end
            5'd11: funct3 = 3'b101;
            5'd12: begin funct3 = 3'b101; is_i = 1'b1; is_sh = 1'b1; end
            5'd13: begin funct3 = 3'b101; funct7 = 7'b0100000; end
            5'd14: begin funct3 = 3'b101; funct7 = 7'b0100000; is_i = 1'b1; is_sh = 1'b1; end
            5'd15: funct3 = 3'b010;
            5'd16: begin funct3 = 3'b010; is_i = 1'b1; end
            5'd17: funct3 = 3'b011;
            5'd18: begin funct3 = 3'b011; is_i = 1'b1; end
            default: op_ok = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Shift amounts must fit 5 bits; other immediates must be sign-extended 12-bit values.
    assign range_ok = is_sh ? (in_imm[31:5] == '0) :
                      is_i  ? (in_imm[31:11] == {21{in_imm[11]}}) : 1'b1;
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:12];
    assign range_ok      = 1'b1;
`endif

    assign legal = op_ok & range_ok;

    always_comb begin
        if (!is_i)
            word = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
        else if (is_sh)
            word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, 7'b0010011};
        else
            word = {in_imm[11:0], in_rs1, funct3, in_rd, 7'b0010011};
    end

    entry_t            fifo_q [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] next_addr, push_addr;
    logic              accept, push, pop;

    assign in_ready  = ~count[1];
    assign out_valid = (count != 2'd0);
    assign out_instr = fifo_q[rd_ptr].instr;
    assign out_addr  = fifo_q[rd_ptr].addr;
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal;
    assign pop       = out_valid & out_ready;
    // restart in the push cycle retargets that very word to BASE_ADDR
    assign push_addr = restart ? BASE_ADDR : next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            next_addr   <= BASE_ADDR;
            err_illegal <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{instr: word, addr: push_addr};
                wr_ptr         <= ~wr_ptr;
                next_addr      <= push_addr + ADDR_W'(4);
            end else if (restart) begin
                next_addr <= BASE_ADDR;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            err_illegal <= accept & ~legal;
            if (accept && !legal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed instruction words, scoreboard queue checked at each pop.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_alu_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_illegal;
    logic [7:0]  illegal_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;
    exp_t        sb [$];
    logic [31:0] exp_next = 32'h0;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: occupancy must track the queue, and every pop must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid_vs_sb", {31'b0, out_valid}, {31'b0, sb.size() != 0});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_instr", out_instr, e.instr);
                    chk("out_addr", out_addr, e.addr);
                end
            end
        end
    end

    // Drive one request, wait (bounded) for acceptance, then record the expected word.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic rst_addr,
                        input logic legal, input logic [31:0] exp_word);
        int waited;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_alu_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; restart = rst_addr;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            if (legal) begin
                e.addr   = rst_addr ? 32'h0 : exp_next;
                e.instr  = exp_word;
                exp_next = e.addr + 32'd4;
                sb.push_back(e);
            end else if (rst_addr) begin
                exp_next = 32'h0;
            end
        end
        #1;
        in_valid = 1'b0; restart = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err", {31'b0, err_illegal}, 32'd0);
        chk("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic R-type, then back-to-back SUB / ADDI
        out_ready = 1'b1;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        #1;
        chk("add_latency_valid", {31'b0, out_valid}, 32'd1);
        chk("add_latency_instr", out_instr, 32'h002081B3);
        drain();
        send(5'd2, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 1'b1, 32'h407302B3);
        send(5'd1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFF00093);
        send(5'd4, 5'd2, 5'd3, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0051C113);
        send(5'd17, 5'd10, 5'd11, 5'd12, 32'd0, 1'b0, 1'b1, 32'h00C5B533);
        send(5'd14, 5'd4, 5'd4, 5'd0, 32'd3, 1'b0, 1'b1, 32'h40325213);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002081B3);
        drain();

        // Backpressure: two accepts fill the buffer, head stays stable
        out_ready = 1'b0;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002081B3);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_head_addr", out_addr, 32'h0);
        @(negedge clk);
        chk("stall_head_addr", out_addr, 32'h0);
        chk("stall_head_instr", out_instr, 32'h002081B3);
        out_ready = 1'b1;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        chk("third_addr_model", exp_next, 32'hC);
        drain();

        // Illegal op: accepted, dropped, pulse, count, address untouched
        send(5'd25, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("illegal_err", {31'b0, err_illegal}, 32'd1);
        chk("illegal_cnt", {24'b0, illegal_cnt}, 32'd1);
        chk("illegal_no_word", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("illegal_err_pulse", {31'b0, err_illegal}, 32'd0);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        drain();

        // Immediate range boundaries
`ifdef ENC_RANGE_CHECK_EN
        send(5'd1, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("range_err", {31'b0, err_illegal}, 32'd1);
        chk("range_cnt", {24'b0, illegal_cnt}, 32'd2);
        send(5'd10, 5'd1, 5'd1, 5'd0, 32'd40, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("shamt_range_cnt", {24'b0, illegal_cnt}, 32'd3);
        send(5'd1, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0, 1'b1, 32'h80000093);
        send(5'd10, 5'd1, 5'd1, 5'd0, 32'd31, 1'b0, 1'b1, 32'h01F09093);
`else
        send(5'd1, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b1, 32'h80000013);
        send(5'd10, 5'd1, 5'd1, 5'd0, 32'd40, 1'b0, 1'b1, 32'h00809093);
        @(negedge clk);
        chk("norange_cnt", {24'b0, illegal_cnt}, 32'd1);
`endif
        drain();

        // Saturation of the drop counter
        repeat (260) send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("cnt_saturate", {24'b0, illegal_cnt}, 32'd255);

        // Reset mid-operation discards buffered words
        out_ready = 1'b0;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_next = 32'h0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_cnt", {24'b0, illegal_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(5'd7, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0020F1B3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
